// File: rtl/weight_update_scheduler_pkg.sv
// Shared types and constants for the weight-update scheduler.
package weight_update_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int unsigned MEM_RD_LAT = 1;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int unsigned layer_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_update_scheduler_handshake_tracker.sv
// One operand's valid/sent pair; complete covers a handshake landing this cycle.
module weight_update_scheduler_handshake_tracker (
  input  logic clk,
  input  logic rst,
  input  logic arm_i,
  input  logic clr_i,
  input  logic ready_i,
  output logic valid_o,
  output logic complete_o
);

  logic valid_q, valid_d;
  logic sent_q, sent_d;
  logic fire;

  assign fire = valid_q & ready_i;

  always_comb begin
    valid_d = valid_q;
    sent_d  = sent_q;
    if (clr_i) begin
      valid_d = 1'b0;
      sent_d  = 1'b0;
    end else if (arm_i) begin
      valid_d = 1'b1;
      sent_d  = 1'b0;
    end else if (fire) begin
      valid_d = 1'b0;
      sent_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sent_q  <= sent_d;
    end
  end

  assign valid_o    = valid_q;
  assign complete_o = sent_q | fire;

endmodule

// File: rtl/weight_update_scheduler.sv
// Walks every layer through read, operand issue, result wait and weight write-back.
module weight_update_scheduler
  import weight_update_scheduler_pkg::*;
#(
  parameter int LAYER_NUM        = 3,
  parameter int LAYER_ADDR_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic                        rd_en,
  output logic [LAYER_ADDR_WIDTH-1:0] rd_addr,
  output logic                        upd_a_valid,
  input  logic                        upd_a_ready,
  output logic                        upd_delta_valid,
  input  logic                        upd_delta_ready,
  output logic                        upd_w_valid,
  input  logic                        upd_w_ready,
  input  logic                        upd_result_valid,
  output logic                        upd_result_ready,
  input  logic                        upd_error,
  output logic                        w_wr_en,
  output logic [LAYER_ADDR_WIDTH-1:0] w_wr_addr
);

  localparam int CNT_W    = layer_cnt_w(LAYER_NUM);
  localparam int RD_CNT_W = layer_cnt_w(MEM_RD_LAT);
  localparam logic [CNT_W-1:0]    LAST    = CNT_W'(LAYER_NUM - 1);
  localparam logic [RD_CNT_W-1:0] RD_LAST = RD_CNT_W'(MEM_RD_LAT - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic                error_q, error_d;

  logic abort_act, start_acc, res_hs, arm, clr;
  logic a_valid, d_valid, w_valid;
  logic a_cmp, d_cmp, w_cmp, all_cmp;

  assign busy      = (state_q == READ) | (state_q == ISSUE) | (state_q == WAIT);
  assign abort_act = abort & busy;
  assign start_acc = start & (state_q == IDLE);
  assign res_hs    = (state_q == WAIT) & upd_result_valid & ~abort_act;
  assign all_cmp   = a_cmp & d_cmp & w_cmp;

  weight_update_scheduler_handshake_tracker u_trk_a (
    .clk(clk), .rst(rst), .arm_i(arm), .clr_i(clr), .ready_i(upd_a_ready),
    .valid_o(a_valid), .complete_o(a_cmp)
  );
  weight_update_scheduler_handshake_tracker u_trk_d (
    .clk(clk), .rst(rst), .arm_i(arm), .clr_i(clr), .ready_i(upd_delta_ready),
    .valid_o(d_valid), .complete_o(d_cmp)
  );
  weight_update_scheduler_handshake_tracker u_trk_w (
    .clk(clk), .rst(rst), .arm_i(arm), .clr_i(clr), .ready_i(upd_w_ready),
    .valid_o(w_valid), .complete_o(w_cmp)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_cnt_d = rd_cnt_q;
    arm      = 1'b0;
    clr      = 1'b0;
    error_d  = start_acc ? 1'b0 : (error_q | (busy & upd_error));
    case (state_q)
      IDLE: if (start_acc) begin
        state_d  = READ;
        cnt_d    = '0;
        rd_cnt_d = '0;
      end
      READ: if (rd_cnt_q == RD_LAST) begin
        state_d  = ISSUE;
        rd_cnt_d = '0;
        arm      = 1'b1;
      end else begin
        rd_cnt_d = rd_cnt_q + RD_CNT_W'(1);
      end
      ISSUE: if (all_cmp) begin
        state_d = WAIT;
        clr     = 1'b1;
      end
      WAIT: if (res_hs) begin
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          state_d = READ;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides whatever the state wanted, including a same-cycle result.
    if (abort_act) begin
      state_d  = IDLE;
      rd_cnt_d = '0;
      arm      = 1'b0;
      clr      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_cnt_q <= rd_cnt_d;
      error_q  <= error_d;
    end
  end

  assign done             = (state_q == DONE);
  assign error            = error_q;
  assign rd_en            = (state_q == READ) & (rd_cnt_q == '0);
  assign rd_addr          = LAYER_ADDR_WIDTH'(cnt_q);
  assign w_wr_addr        = LAYER_ADDR_WIDTH'(cnt_q);
  assign upd_a_valid      = a_valid & ~abort_act;
  assign upd_delta_valid  = d_valid & ~abort_act;
  assign upd_w_valid      = w_valid & ~abort_act;
  assign upd_result_ready = (state_q == WAIT) & ~abort_act;
  assign w_wr_en          = res_hs;

endmodule

// File: tb/tb_weight_update_scheduler.sv
// Directed and randomized runs of the scheduler against an event-level reference model.
module tb_weight_update_scheduler;

  localparam int N  = 3;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic          busy, done, error, rd_en;
  logic [AW-1:0] rd_addr, w_wr_addr;
  logic          upd_a_valid, upd_a_ready, upd_delta_valid, upd_delta_ready;
  logic          upd_w_valid, upd_w_ready, upd_result_valid, upd_result_ready;
  logic          upd_error, w_wr_en;

  int vecs = 0;
  int errs = 0;
  bit exp_err = 1'b0;

  always #5 clk = ~clk;

  weight_update_scheduler #(.LAYER_NUM(N), .LAYER_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .error(error),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .upd_a_valid(upd_a_valid), .upd_a_ready(upd_a_ready),
    .upd_delta_valid(upd_delta_valid), .upd_delta_ready(upd_delta_ready),
    .upd_w_valid(upd_w_valid), .upd_w_ready(upd_w_ready),
    .upd_result_valid(upd_result_valid), .upd_result_ready(upd_result_ready),
    .upd_error(upd_error), .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_valids"}, {upd_a_valid, upd_delta_valid, upd_w_valid}, 0);
    chk({tag, "_res_ready"}, upd_result_ready, 0);
    chk({tag, "_wr_en"}, w_wr_en, 0);
  endtask

  task automatic clear_inputs();
    start = 0; abort = 0; upd_a_ready = 0; upd_delta_ready = 0; upd_w_ready = 0;
    upd_result_valid = 0; upd_error = 0;
  endtask

  // One complete run. Negative layer arguments disable the error pulse / abort.
  task automatic run(input int lat, input int da, input int dd, input int dw,
                     input int err_layer, input int abort_layer, input bit mid_start);
    int layer = 0, ia = 0, wa = 0, cyc = 0, dones = 0, n_rd, n_wr;
    bit e_rd = 1, e_va = 0, e_vd = 0, e_vw = 0, e_rr = 0, e_done = 0, e_busy;
    bit sa = 0, sd = 0, sw = 0, fin = 0, aborted = 0, mid_used = 0;
    bit ar, dr, wr, rv, ab, ue, st, hs_a, hs_d, hs_w;
    int rd_q[$];
    int wr_q[$];

    @(posedge clk); #1;
    clear_inputs();
    start = 1;
    @(negedge clk);
    chk("start_cycle_busy", busy, 0);
    chk("start_cycle_error", error, exp_err);
    exp_err = 0;
    @(posedge clk); #1;

    while (!fin) begin
      ar = e_va ? (ia >= da) : 1'($urandom_range(0, 1));
      dr = e_vd ? (ia >= dd) : 1'($urandom_range(0, 1));
      wr = e_vw ? (ia >= dw) : 1'($urandom_range(0, 1));
      rv = e_rr && (wa >= lat);
      ab = (layer == abort_layer) && rv;
      ue = (layer == err_layer) && e_rr && (wa == 0);
      st = mid_start && !mid_used && (layer == 1) && (e_va || e_vd || e_vw);
      mid_used |= st;
      start = st;
      abort = ab | (e_done & 1'($urandom_range(0, 1)));
      upd_a_ready = ar; upd_delta_ready = dr; upd_w_ready = wr;
      upd_result_valid = rv; upd_error = ue;
      e_busy = e_rd | e_va | e_vd | e_vw | e_rr;
      hs_a = e_va & ar; hs_d = e_vd & dr; hs_w = e_vw & wr;

      @(negedge clk);
      chk("rd_en", rd_en, e_rd);
      if (e_rd) chk("rd_addr", rd_addr, layer);
      chk("a_valid", upd_a_valid, e_va);
      chk("delta_valid", upd_delta_valid, e_vd);
      chk("w_valid", upd_w_valid, e_vw);
      chk("result_ready", upd_result_ready, e_rr && !ab);
      chk("wr_en", w_wr_en, e_rr && rv && !ab);
      if (e_rr && rv && !ab) chk("wr_addr", w_wr_addr, layer);
      chk("done", done, e_done);
      chk("busy", busy, e_busy);
      chk("error", error, exp_err);
      if (rd_en) rd_q.push_back(int'(rd_addr));
      if (w_wr_en) wr_q.push_back(int'(w_wr_addr));
      if (done) dones++;

      exp_err = exp_err | (e_busy & ue);
      if (ab) begin
        aborted = 1; fin = 1;
      end else if (e_rd) begin
        e_rd = 0; e_va = 1; e_vd = 1; e_vw = 1; sa = 0; sd = 0; sw = 0; ia = 0;
      end else if (e_va || e_vd || e_vw) begin
        if (hs_a) begin e_va = 0; sa = 1; end
        if (hs_d) begin e_vd = 0; sd = 1; end
        if (hs_w) begin e_vw = 0; sw = 1; end
        ia++;
        if (sa && sd && sw) begin e_rr = 1; wa = 0; end
      end else if (e_rr) begin
        if (rv) begin
          e_rr = 0;
          if (layer == N - 1) e_done = 1;
          else begin layer++; e_rd = 1; end
        end else wa++;
      end else begin
        fin = 1;
      end
      cyc++;
      if (cyc > 300) begin
        chk("run_timeout", 1, 0);
        fin = 1;
      end
      @(posedge clk); #1;
    end

    clear_inputs();
    abort = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk_quiet("after_run");
    chk("after_run_error", error, exp_err);
    @(posedge clk); #1;
    abort = 0;

    n_rd = aborted ? layer + 1 : N;
    n_wr = aborted ? layer : N;
    chk("read_count", rd_q.size(), n_rd);
    for (int i = 0; i < rd_q.size() && i < n_rd; i++) chk("read_seq", rd_q[i], i);
    chk("write_count", wr_q.size(), n_wr);
    for (int i = 0; i < wr_q.size() && i < n_wr; i++) chk("write_seq", wr_q[i], i);
    chk("done_count", dones, aborted ? 0 : 1);
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    #12;
    chk_quiet("reset");
    chk("reset_error", error, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_wr_addr", w_wr_addr, 0);
    @(posedge clk); #1;
    rst = 0;
    exp_err = 0;

    run(4, 0, 0, 0, -1, -1, 0);
    run(3, 2, 5, 0, -1, -1, 0);
    run($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 4),
        $urandom_range(0, 4), -1, -1, 1);
    run($urandom_range(1, 5), $urandom_range(0, 3), $urandom_range(0, 3),
        $urandom_range(0, 3), 2, -1, 0);
    run($urandom_range(0, 3), 0, 1, 2, -1, -1, 0);
    run($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
        $urandom_range(0, 3), -1, 1, 0);
    run(2, 1, 0, 3, -1, -1, 0);

    // Asynchronous reset landing mid-ISSUE, between clock edges.
    @(posedge clk); #1;
    clear_inputs();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_reset_valid", {upd_a_valid, upd_delta_valid, upd_w_valid}, 3'b111);
    #2 rst = 1;
    #1;
    chk_quiet("async_reset");
    chk("async_reset_error", error, 0);
    chk("async_reset_rd_addr", rd_addr, 0);
    @(posedge clk); #1;
    rst = 0;
    exp_err = 0;
    run($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
        $urandom_range(0, 3), -1, -1, 0);

    for (int k = 0; k < 4; k++) begin
      run($urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 5),
          $urandom_range(0, 5), $urandom_range(0, 3) - 1, -1, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/weight_update_scheduler.md
Name: weight_update_scheduler

Overview:
Sequences the weight-update datapath (`weight_updater`) across all layers of the network after a backward pass. For each layer it:
- reads the activation, delta and weight memories at the layer address;
- presents the three operands to the updater over independent valid/ready handshakes;
- accepts the updated weight matrix and writes it back to the weight memory.

Operand and result data buses connect memory to updater directly. This block owns only addresses, enables, handshakes, sequencing and status.

Parameters:
- LAYER_NUM, 3, number of weight matrices to update per run (must be >= 1).
- LAYER_ADDR_WIDTH, 2, width of the layer address; must satisfy 2**LAYER_ADDR_WIDTH >= LAYER_NUM.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to begin a full update run.
- abort  in  1  abandons the run in progress.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse when the last layer's write completes.
- error  out  1  sticky OR of upd_error sampled while busy; cleared by an accepted start.
- rd_en  out  1  read strobe shared by the activation, delta and weight memories.
- rd_addr  out  LAYER_ADDR_WIDTH  layer address for those reads.
- upd_a_valid  out  1  activation operand valid.
- upd_a_ready  in  1  activation operand ready.
- upd_delta_valid  out  1  delta operand valid.
- upd_delta_ready  in  1  delta operand ready.
- upd_w_valid  out  1  weight operand valid.
- upd_w_ready  in  1  weight operand ready.
- upd_result_valid  in  1  updated weights valid.
- upd_result_ready  out  1  scheduler accepts the result.
- upd_error  in  1  overflow flag from the updater.
- w_wr_en  out  1  weight memory write strobe.
- w_wr_addr  out  LAYER_ADDR_WIDTH  weight memory write address.

Behaviour:
- Reset: all outputs 0; state IDLE; layer counter 0; sent flags 0.
- Memory contract: reads are synchronous with 1-cycle latency. Read data stays stable until the next rd_en.
- State IDLE:
  - On start: clear error and counter, go to READ. busy rises the next cycle.
  - start while busy is ignored.
- State READ:
  - rd_en=1 and rd_addr=counter for exactly one cycle, then go to ISSUE.
- State ISSUE:
  - On entry, upd_a_valid, upd_delta_valid and upd_w_valid are all high.
  - Each valid drops independently the cycle after its own valid&ready and sets its sent flag.
  - A valid never drops before its handshake, except on abort or reset.
  - Handshakes may complete in any order or simultaneously.
  - When all three have completed (including one completing in the current cycle), go to WAIT and clear the sent flags.
- State WAIT:
  - upd_result_ready=1.
  - On upd_result_valid, in the same cycle, combinationally: w_wr_en=1 and w_wr_addr=counter.
  - Next state:
    - if counter==LAYER_NUM-1, go to DONE;
    - else increment counter and go to READ.
- State DONE:
  - done=1 for one cycle, then IDLE.
  - busy is low in the DONE cycle.
- rd_addr and w_wr_addr hold the counter value outside their strobes. Memories must ignore them when strobes are low.
- Abort (busy states only):
  - Next state IDLE.
  - All valids, upd_result_ready and w_wr_en go low that cycle.
  - No done pulse; error is retained.
  - The updater must be reset or drained by the system; this block does not track in-flight data after abort.
  - Abort beats a same-cycle result handshake: no write occurs.
  - Abort in IDLE or DONE has no effect.
- Error: error <= error | (busy & upd_error), updated every cycle.
- Ordering guarantee: a layer's write strictly precedes the next layer's read, so there are no read/write hazards on the weight memory.
- Minimum per-layer latency, excluding updater latency: 1 READ cycle + 1 ISSUE cycle + 1 WAIT cycle.
- Mid-operation rst: immediate return to reset values.

Decomposition:
- Shared package holds:
  - the state encoding localparams (IDLE, READ, ISSUE, WAIT, DONE);
  - the layer counter width derivation;
  - the memory read latency constant (1).
- One natural sub-module: handshake_tracker. It is instantiated three times, once per operand. Each instance holds a valid/sent flag pair and exposes a "complete" signal to the FSM.
- No other sub-modules.

Test Plan:
- Nominal run, LAYER_NUM=3, all readies tied 1, updater model latency 4:
  - rd_addr sequence is 0,1,2;
  - exactly three w_wr_en pulses, at addresses 0,1,2;
  - done pulses once; busy falls in the done cycle.
- Staggered readies:
  - upd_a_ready delayed 2 cycles, upd_delta_ready delayed 5, upd_w_ready immediate;
  - each valid drops only after its own handshake;
  - WAIT is entered the cycle after the delta handshake.
- Simultaneous events: start asserted while busy in layer 1 -> ignored; the run completes normally with one done pulse.
- Error handling:
  - upd_error pulses 1 cycle during layer 2 -> error=1 held after done;
  - the next start clears it to 0 the following cycle.
- Abort:
  - abort in the same cycle as upd_result_valid on layer 1 -> no w_wr_en, no done, state IDLE next cycle;
  - a subsequent start runs layers 0..2 cleanly.
- Reset:
  - async rst asserted mid-ISSUE (between clock edges) -> all outputs 0 immediately;
  - after release and start, rd_addr restarts at 0.
